// File: rtl/ram_loader_if.sv
// Handshake and RAM-side bus between ram_loader and its environment.
// The loader takes the master view; the source, RAM and controller take the slave view.
interface ram_loader_if;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] ram_din;
  logic [3:0] ram_addr;
  logic       ram_prog;
  logic       ram_n_ce;
  logic [7:0] ram_dout;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] err_addr;

  modport master (
    input  start, in_valid, in_data, ram_dout,
    output in_ready, ram_din, ram_addr, ram_prog, ram_n_ce,
           busy, done, error, err_addr
  );

  modport slave (
    output start, in_valid, in_data, ram_dout,
    input  in_ready, ram_din, ram_addr, ram_prog, ram_n_ce,
           busy, done, error, err_addr
  );
endinterface

// File: rtl/ram_loader.sv
// Streams 16 bytes into a small RAM, then optionally reads them back and
// compares against a shadow copy, flagging the first mismatching address.
module ram_loader #(
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic         clk,
  input  logic         n_rst,
  ram_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, V_ADDR, V_WAIT, V_CMP, DONE, ERROR
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] ram_din_q, ram_din_d;
  logic [3:0] ram_addr_q, ram_addr_d;
  logic       ram_prog_q, ram_prog_d;
  logic       ram_n_ce_q, ram_n_ce_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic [3:0] err_addr_q, err_addr_d;
  logic [7:0] shadow_q [16];
  logic [7:0] shadow_d [16];
  logic       handshake;

  assign handshake = bus.in_valid && (state_q == LOAD);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_din_d  = ram_din_q;
    ram_addr_d = ram_addr_q;
    ram_prog_d = 1'b0;
    err_addr_d = err_addr_q;
    shadow_d   = shadow_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (bus.start) begin
          state_d    = LOAD;
          cnt_d      = '0;
          err_addr_d = '0;
        end
      end
      LOAD: begin
        if (handshake) begin
          ram_din_d        = bus.in_data;
          ram_addr_d       = cnt_q;
          ram_prog_d       = 1'b1;
          shadow_d[cnt_q]  = bus.in_data;
          cnt_d            = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = VERIFY_EN ? V_ADDR : DONE;
            cnt_d   = '0;
          end
        end
      end
      V_ADDR: begin
        ram_addr_d = cnt_q;
        state_d    = V_WAIT;
      end
      V_WAIT: state_d = V_CMP;
      V_CMP: begin
        if (bus.ram_dout != shadow_q[cnt_q]) begin
          state_d    = ERROR;
          err_addr_d = cnt_q;
        end else if (cnt_q == 4'd15) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = V_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status and chip-enable are decoded from the next state so the
    // registered outputs line up with the state they describe.
    busy_d     = (state_d == LOAD) || (state_d == V_ADDR) ||
                 (state_d == V_WAIT) || (state_d == V_CMP);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERROR);
    ram_n_ce_d = !((state_d == V_WAIT) || (state_d == V_CMP));
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ram_din_q  <= '0;
      ram_addr_q <= '0;
      ram_prog_q <= 1'b0;
      ram_n_ce_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ram_din_q  <= ram_din_d;
      ram_addr_q <= ram_addr_d;
      ram_prog_q <= ram_prog_d;
      ram_n_ce_q <= ram_n_ce_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign bus.in_ready = (state_q == LOAD);
  assign bus.ram_din  = ram_din_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_prog = ram_prog_q;
  assign bus.ram_n_ce = ram_n_ce_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.err_addr = err_addr_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: one instance with readback, one without,
// each attached to a behavioural 16x8 RAM.
module tb_ram_loader;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  ram_loader_if bv ();
  ram_loader_if bn ();

  ram_loader #(.VERIFY_EN(1'b1)) dut_v (.clk(clk), .n_rst(n_rst), .bus(bv.master));
  ram_loader #(.VERIFY_EN(1'b0)) dut_nv (.clk(clk), .n_rst(n_rst), .bus(bn.master));

  int tests = 0;
  int fails = 0;

  logic [7:0] mem_v [16];
  logic [7:0] mem_n [16];
  int         wr_n [16];
  int         wsnap [16];
  int         prog_total_v = 0;
  int         prog_total_n = 0;
  int         overlap = 0;
  logic [3:0] last_rd = '0;
  logic       corrupt = 1'b0;

  // RAM models: write on the negedge after ram_prog, registered read on posedge.
  always @(negedge clk) begin
    if (bv.ram_prog === 1'b1) begin
      mem_v[bv.ram_addr] <= (corrupt && bv.ram_addr == 4'd7) ? 8'hFF : bv.ram_din;
      prog_total_v <= prog_total_v + 1;
    end
    if (bn.ram_prog === 1'b1) begin
      mem_n[bn.ram_addr] <= bn.ram_din;
      wr_n[bn.ram_addr]  <= wr_n[bn.ram_addr] + 1;
      prog_total_n <= prog_total_n + 1;
    end
    if ((bv.ram_prog === 1'b1 && bv.ram_n_ce === 1'b0) ||
        (bn.ram_prog === 1'b1 && bn.ram_n_ce === 1'b0))
      overlap <= overlap + 1;
  end

  always @(posedge clk) begin
    if (bv.ram_n_ce === 1'b0) begin
      bv.ram_dout <= mem_v[bv.ram_addr];
      last_rd     <= bv.ram_addr;
    end
  end

  assign bn.ram_dout = 8'h00;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int busy_cnt;
    int guard;
    int pv0;
    int pn0;
    logic ok;

    n_rst = 1'b0;
    bv.start = 1'b0; bv.in_valid = 1'b0; bv.in_data = '0;
    bn.start = 1'b0; bn.in_valid = 1'b0; bn.in_data = '0;
    tick; tick;

    check("rst_flags_v", {bv.busy, bv.done, bv.error, bv.ram_prog, bv.ram_n_ce, bv.in_ready}, 6'b000010);
    check("rst_bus_v", {bv.ram_din, bv.ram_addr, bv.err_addr}, 16'h0000);
    check("rst_flags_nv", {bn.busy, bn.done, bn.error, bn.ram_prog, bn.ram_n_ce, bn.in_ready}, 6'b000010);
    check("rst_bus_nv", {bn.ram_din, bn.ram_addr, bn.err_addr}, 16'h0000);
    n_rst = 1'b1;
    tick;

    // in_valid outside LOAD is never accepted
    bn.in_valid = 1'b1;
    tick;
    check("idle_no_handshake", {bn.in_ready, bn.ram_prog, bn.busy}, 3'b000);
    bn.in_valid = 1'b0;

    // Full back-to-back load without readback
    pn0 = prog_total_n;
    bn.start = 1'b1;
    tick;
    bn.start = 1'b0;
    check("full_enter_load", {bn.in_ready, bn.busy, bn.done}, 3'b110);
    bn.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bn.in_data = i[7:0];
      tick;
      check("full_wr", {bn.ram_prog, bn.ram_addr, bn.ram_din}, {1'b1, i[3:0], i[7:0]});
    end
    check("full_done", {bn.done, bn.busy, bn.in_ready, bn.error}, 4'b1000);
    tick;
    check("full_no_extra_prog", bn.ram_prog, 1'b0);
    bn.in_valid = 1'b0;
    tick;
    check("full_prog_count", prog_total_n - pn0, 16);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) if (mem_n[i] !== i[7:0]) ok = 1'b0;
    check("full_mem", ok, 1'b1);

    // Gapped load: in_valid alternates, no writes during gaps
    for (int i = 0; i < 16; i++) wsnap[i] = wr_n[i];
    pn0 = prog_total_n;
    bn.start = 1'b1;
    tick;
    bn.start = 1'b0;
    check("gap_done_cleared", {bn.done, bn.busy}, 2'b01);
    for (int i = 0; i < 16; i++) begin
      bn.in_valid = 1'b1;
      bn.in_data  = 8'hA0 + i[7:0];
      tick;
      bn.in_valid = 1'b0;
      if (i == 3 || i == 15)
        check("gap_wr", {bn.ram_prog, bn.ram_addr, bn.ram_din}, {1'b1, i[3:0], 8'hA0 + i[7:0]});
      tick;
      if (i == 3) check("gap_idle_prog", bn.ram_prog, 1'b0);
    end
    check("gap_done", {bn.done, bn.busy}, 2'b10);
    check("gap_prog_count", prog_total_n - pn0, 16);
    ok = 1'b1;
    for (int i = 0; i < 16; i++)
      if (mem_n[i] !== (8'hA0 + i[7:0]) || wr_n[i] != wsnap[i] + 1) ok = 1'b0;
    check("gap_mem_once", ok, 1'b1);

    // Verify pass, in_valid left high throughout (ignored outside LOAD)
    bv.start = 1'b1; bv.in_valid = 1'b1; bv.in_data = 8'h5A;
    tick;
    bv.start = 1'b0;
    busy_cnt = 0; guard = 0;
    while (bv.busy && guard < 200) begin busy_cnt++; tick; guard++; end
    bv.in_valid = 1'b0;
    check("vpass_busy_cycles", busy_cnt, 64);
    check("vpass_flags", {bv.done, bv.error, bv.ram_n_ce, bv.ram_prog}, 4'b1010);

    // start during V_WAIT is ignored
    bv.start = 1'b1; bv.in_data = 8'h3C;
    tick;
    bv.start = 1'b0;
    bv.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) tick;
    bv.in_valid = 1'b0;
    check("ign_vaddr", {bv.in_ready, bv.ram_n_ce, bv.busy}, 3'b011);
    tick;
    check("ign_vwait", {bv.ram_n_ce, bv.ram_addr}, {1'b0, 4'd0});
    bv.start = 1'b1;
    tick;
    bv.start = 1'b0;
    busy_cnt = 2; guard = 0;
    while (bv.busy && guard < 200) begin busy_cnt++; tick; guard++; end
    check("ign_verify_cycles", busy_cnt, 48);
    check("ign_flags", {bv.done, bv.error}, 2'b10);

    // Verify fail: the RAM stores 0xFF at address 7
    corrupt = 1'b1;
    bv.start = 1'b1;
    tick;
    bv.start = 1'b0;
    bv.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bv.in_data = 8'h10 + i[7:0];
      tick;
    end
    bv.in_valid = 1'b0;
    busy_cnt = 0; guard = 0;
    while (bv.busy && guard < 200) begin busy_cnt++; tick; guard++; end
    check("vfail_verify_cycles", busy_cnt, 24);
    check("vfail_flags", {bv.done, bv.error, bv.ram_n_ce}, 3'b011);
    check("vfail_err_addr", bv.err_addr, 4'd7);
    check("vfail_last_read", last_rd, 4'd7);
    tick; tick; tick;
    check("vfail_hold", {bv.error, bv.err_addr, bv.ram_n_ce, last_rd}, {1'b1, 4'd7, 1'b1, 4'd7});
    corrupt = 1'b0;

    // Reset mid-load, then reload from address 0
    pv0 = prog_total_v;
    bv.start = 1'b1;
    tick;
    bv.start = 1'b0;
    check("rml_error_cleared", {bv.busy, bv.error, bv.done}, 3'b100);
    bv.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bv.in_data = 8'h30 + i[7:0];
      tick;
    end
    check("rml_fifth_wr", {bv.ram_prog, bv.ram_addr, bv.ram_din}, {1'b1, 4'd4, 8'h34});
    n_rst = 1'b0;
    tick;
    check("rml_reset_out", {bv.ram_prog, bv.in_ready, bv.busy, bv.ram_n_ce}, 4'b0001);
    tick;
    check("rml_write_count", prog_total_v - pv0, 5);
    n_rst = 1'b1;
    bv.in_valid = 1'b0;
    tick;
    bv.start = 1'b1;
    tick;
    bv.start = 1'b0;
    bv.in_valid = 1'b1;
    bv.in_data = 8'hC0;
    tick;
    check("rml_reload_addr0", {bv.ram_prog, bv.ram_addr, bv.ram_din}, {1'b1, 4'd0, 8'hC0});
    for (int i = 1; i < 16; i++) begin
      bv.in_data = 8'hC0 + i[7:0];
      tick;
    end
    bv.in_valid = 1'b0;
    busy_cnt = 0; guard = 0;
    while (bv.busy && guard < 200) begin busy_cnt++; tick; guard++; end
    check("rml_verify_cycles", busy_cnt, 48);
    check("rml_flags", {bv.done, bv.error}, 2'b10);

    check("prog_ce_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter: VERIFY_EN, default 1, meaning 1 = read back and compare all 16 bytes after the load, 0 = skip the readback.
REQ-002 Port: clk  input  1  system clock; all state changes on posedge clk.
REQ-003 Port: n_rst  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  one-cycle request to begin a 16-byte load; ignored unless in IDLE, DONE or ERROR.
REQ-005 Port: in_valid  input  1  source byte valid.
REQ-006 Port: in_data  input  8  source byte.
REQ-007 Port: in_ready  output  1  loader accepts in_data this cycle.
REQ-008 Port: ram_din  output  8  write data to the 16-byte RAM.
REQ-009 Port: ram_addr  output  4  RAM address.
REQ-010 Port: ram_prog  output  1  RAM write enable; the RAM writes on the negedge following its assertion.
REQ-011 Port: ram_n_ce  output  1  RAM output enable, active-low.
REQ-012 Port: ram_dout  input  8  RAM read data, registered by the RAM on posedge clk.
REQ-013 Port: busy  output  1  high in LOAD and any VERIFY state.
REQ-014 Port: done  output  1  high in DONE.
REQ-015 Port: error  output  1  high in ERROR.
REQ-016 Port: err_addr  output  4  address of the first readback mismatch.

Function
REQ-017 States SHALL be: IDLE, LOAD, V_ADDR, V_WAIT, V_CMP, DONE, ERROR.
REQ-018 All outputs SHALL be registered, except in_ready, which SHALL equal (state==LOAD).
REQ-019 IDLE/DONE/ERROR + start -> LOAD; cnt<=0; done/error clear that cycle.
REQ-020 LOAD: on in_valid&&in_ready: ram_din<=in_data; ram_addr<=cnt; ram_prog<=1 for exactly one cycle; cnt<=cnt+1 (4-bit).
REQ-021 LOAD: cycles without a handshake SHALL drive ram_prog<=0, so idle gaps in in_valid produce no writes.
REQ-022 Back-to-back handshakes SHALL produce one write per cycle at consecutive addresses.
REQ-023 On the 16th accepted byte (cnt==15): if VERIFY_EN -> V_ADDR with cnt<=0, else -> DONE; no further bytes are accepted.
REQ-024 Load latency: byte accepted at posedge k is written to the RAM at the negedge within cycle k.
REQ-025 V_ADDR: ram_addr<=cnt, ram_n_ce<=0, ram_prog<=0 -> V_WAIT.
REQ-026 V_WAIT: no output change -> V_CMP (the RAM registers mem[cnt] on this edge).
REQ-027 V_CMP: compare ram_dout with shadow[cnt], the 16x8 copy captured at load.
REQ-028 V_CMP mismatch -> ERROR, err_addr<=cnt.
REQ-029 V_CMP match with cnt==15 -> DONE.
REQ-030 V_CMP match with cnt!=15 -> cnt<=cnt+1 -> V_ADDR.
REQ-031 Each verified byte SHALL take 3 cycles; a full verify SHALL take 48 cycles.
REQ-032 ram_n_ce SHALL be 0 only in V_WAIT and V_CMP (and the registered V_ADDR exit); it SHALL be 1 in all other states.
REQ-033 ram_prog and ram_n_ce==0 SHALL never be asserted in the same cycle.
REQ-034 start while busy SHALL be ignored.
REQ-035 in_valid outside LOAD SHALL be ignored, with no handshake.
REQ-036 DONE and ERROR SHALL hold until start or reset; err_addr SHALL hold until the next start.

Reset
REQ-037 On posedge clk with n_rst==0: state=IDLE, cnt=0, ram_prog=0, ram_n_ce=1, ram_din=0, ram_addr=0, busy=0, done=0, error=0, err_addr=0; shadow contents are don't-care.
REQ-038 Reset mid-LOAD or mid-VERIFY SHALL abort the operation immediately with no further RAM write; RAM contents already written are not restored.

Verification
REQ-039 Scenario full load: start, stream 0x00..0x0F back-to-back, VERIFY_EN=0 -> 16 single-cycle ram_prog pulses at addr 0..15; done=1 on the cycle after the 16th handshake.
REQ-040 Scenario gapped load: in_valid toggled 1/0 with bytes 0xA0..0xAF -> no ram_prog in gap cycles; each address written exactly once; all 16 bytes land at correct addresses.
REQ-041 Scenario verify pass: load 0x5A repeated x16 with VERIFY_EN=1 and a RAM model attached -> busy for 16+48 cycles after the first handshake; done=1, error=0.
REQ-042 Scenario verify fail: RAM model corrupts addr 7 to 0xFF -> error=1, err_addr=7; done=0; no compares after addr 7.
REQ-043 Scenario reset mid-load: n_rst=0 after the 5th byte -> next cycle state IDLE, ram_prog=0, in_ready=0; a subsequent start reloads from addr 0.
REQ-044 Scenario ignored start: start pulsed during V_WAIT -> no state or cnt change; verify completes normally.
